// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: valid/ready front-end for a registered ALU that predicts each
// result, flags ALU mismatches and keeps saturating operation/error counters.
module alu_cmd_issuer #(
    parameter int OPCODE_WIDTH = 2,
    parameter int DATA_WIDTH   = 1,
    parameter int TAG_WIDTH    = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPCODE_WIDTH:0]   req_opcode,
    input  logic [DATA_WIDTH:0]     req_op1,
    input  logic [DATA_WIDTH:0]     req_op2,
    input  logic [TAG_WIDTH-1:0]    req_tag,
    output logic [OPCODE_WIDTH:0]   alu_opcode,
    output logic [DATA_WIDTH:0]     alu_op1,
    output logic [DATA_WIDTH:0]     alu_op2,
    input  logic [DATA_WIDTH:0]     alu_result,
    input  logic                    alu_carry,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH:0]     rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_zero,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    output logic                    rsp_mismatch,
    output logic [CNT_WIDTH-1:0]    op_count,
    output logic [CNT_WIDTH-1:0]    err_count
);
    localparam int E = DATA_WIDTH + 2;
    localparam logic [OPCODE_WIDTH:0] OP_ADD = 0, OP_SUB = 1, OP_INC = 2, OP_DEC = 3;
    localparam logic [OPCODE_WIDTH:0] OP_AND = 4, OP_OR = 5, OP_NAND = 6, OP_XOR = 7;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t               state;
    logic [E-1:0]         a, b, ext;
    logic [DATA_WIDTH:0]  exp_result;
    logic                 exp_carry, exp_zero;
    logic [TAG_WIDTH-1:0] tag_q;
    assign a = {1'b0, req_op1};
    assign b = {1'b0, req_op2};
    // Logic ops are zero-extended so their carry bit is always 0.
    always_comb begin
        ext = '0;
        case (req_opcode)
            OP_ADD:  ext = a + b;
            OP_SUB:  ext = a - b;
            OP_INC:  ext = a + E'(1);
            OP_DEC:  ext = a - E'(1);
            OP_AND:  ext = {1'b0, req_op1 & req_op2};
            OP_OR:   ext = {1'b0, req_op1 | req_op2};
            OP_NAND: ext = {1'b0, ~(req_op1 & req_op2)};
            OP_XOR:  ext = {1'b0, req_op1 ^ req_op2};
            default: ext = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            alu_opcode   <= '0;
            alu_op1      <= '0;
            alu_op2      <= '0;
            tag_q        <= '0;
            exp_result   <= '0;
            exp_carry    <= 1'b0;
            exp_zero     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_tag      <= '0;
            rsp_mismatch <= 1'b0;
            op_count     <= '0;
            err_count    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    alu_opcode <= req_opcode;
                    alu_op1    <= req_op1;
                    alu_op2    <= req_op2;
                    tag_q      <= req_tag;
                    exp_result <= ext[DATA_WIDTH:0];
                    exp_carry  <= ext[DATA_WIDTH+1];
                    exp_zero   <= (ext == '0);
                    req_ready  <= 1'b0;
                    state      <= ISSUE;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    rsp_result   <= alu_result;
                    rsp_carry    <= alu_carry;
                    rsp_zero     <= alu_zero;
                    rsp_tag      <= tag_q;
                    rsp_mismatch <= {alu_carry, alu_result, alu_zero} != {exp_carry, exp_result, exp_zero};
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    op_count  <= &op_count ? op_count : op_count + CNT_WIDTH'(1);
                    err_count <= (rsp_mismatch && !(&err_count)) ? err_count + CNT_WIDTH'(1) : err_count;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
